// File: rtl/pattern_tx_pkg.sv
// Shared constants and FSM state encoding for the pattern_tx serial transmitter.
package pattern_tx_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int LEN_W_DEF = 5;
  localparam int CNT_W_DEF = 8;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/seq101_counter.sv
// Saturating counter of overlapping "101" occurrences in a bit stream.
// Holds a 2-bit history of the most recently emitted bits.
module seq101_counter
  import pattern_tx_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             bit_en,
  input  logic             bit_in,
  output logic [CNT_W-1:0] hit_cnt
);

  // hist[1] is the older bit, hist[0] the most recent one
  logic [1:0] hist;
  logic       hit;
  logic       sat;

  // Hit detection on the incoming bit and the saturation flag
  always_comb begin
    hit = 1'b0;
    sat = &hit_cnt;
    if (bit_en && bit_in && (hist == 2'b10)) begin
      hit = 1'b1;
    end else begin
      hit = 1'b0;
    end
  end

  // History and counter update; a clear starts a fresh history with the first bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist    <= 2'b00;
      hit_cnt <= {CNT_W{1'b0}};
    end else if (clr) begin
      hist    <= {1'b0, bit_in & bit_en};
      hit_cnt <= {CNT_W{1'b0}};
    end else if (bit_en) begin
      hist <= {hist[0], bit_in};
      if (hit && !sat) begin
        hit_cnt <= hit_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: rtl/pattern_tx.sv
// Serial pattern transmitter: shifts a programmable pattern out MSB-first with
// optional gapless repetition, and counts overlapping "101" hits in the stream.
module pattern_tx
  import pattern_tx_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int LEN_W = LEN_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic             repeat_en,  // restart the frame with no gap when high at a frame end
  output logic             x,
  output logic             valid,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] hit_cnt
);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_nxt;
  logic [WIDTH-1:0] reload;
  logic [WIDTH-1:0] reload_nxt;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] len_nxt;
  logic [LEN_W-1:0] remaining;
  logic [LEN_W-1:0] rem_nxt;
  logic [LEN_W-1:0] eff_len;
  logic             x_nxt;
  logic             valid_nxt;
  logic             busy_nxt;
  logic             done_nxt;
  logic             accept;
  logic             emit;

  // Requested length clamped to the pattern width
  always_comb begin
    if (len > LEN_W'(WIDTH)) begin
      eff_len = LEN_W'(WIDTH);
    end else begin
      eff_len = len;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt  = state;
    shreg_nxt  = shreg;
    reload_nxt = reload;
    len_nxt    = len_q;
    rem_nxt    = remaining;
    x_nxt      = 1'b0;
    valid_nxt  = 1'b0;
    busy_nxt   = 1'b0;
    done_nxt   = 1'b0;
    accept     = 1'b0;
    emit       = 1'b0;
    case (state)
      IDLE: begin
        if (start && (len != {LEN_W{1'b0}})) begin
          accept     = 1'b1;
          emit       = 1'b1;
          reload_nxt = pattern;
          len_nxt    = eff_len;
          // Left-align so that pattern[L-1] sits at the MSB
          shreg_nxt  = pattern << (LEN_W'(WIDTH) - eff_len);
          x_nxt      = shreg_nxt[WIDTH-1];
          valid_nxt  = 1'b1;
          busy_nxt   = 1'b1;
          rem_nxt    = eff_len - LEN_W'(1);
          state_nxt  = SHIFT;
        end else begin
          state_nxt = IDLE;
        end
      end
      SHIFT: begin
        if (remaining != {LEN_W{1'b0}}) begin
          emit      = 1'b1;
          shreg_nxt = {shreg[WIDTH-2:0], 1'b0};
          x_nxt     = shreg_nxt[WIDTH-1];
          valid_nxt = 1'b1;
          busy_nxt  = 1'b1;
          rem_nxt   = remaining - LEN_W'(1);
          state_nxt = SHIFT;
        end else if (repeat_en) begin
          emit      = 1'b1;
          shreg_nxt = reload << (LEN_W'(WIDTH) - len_q);
          x_nxt     = shreg_nxt[WIDTH-1];
          valid_nxt = 1'b1;
          busy_nxt  = 1'b1;
          rem_nxt   = len_q - LEN_W'(1);
          state_nxt = SHIFT;
        end else begin
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      shreg     <= {WIDTH{1'b0}};
      reload    <= {WIDTH{1'b0}};
      len_q     <= {LEN_W{1'b0}};
      remaining <= {LEN_W{1'b0}};
      x         <= 1'b0;
      valid     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      shreg     <= shreg_nxt;
      reload    <= reload_nxt;
      len_q     <= len_nxt;
      remaining <= rem_nxt;
      x         <= x_nxt;
      valid     <= valid_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
    end
  end

  seq101_counter #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (accept),
    .bit_en (emit),
    .bit_in (x_nxt),
    .hit_cnt(hit_cnt)
  );

endmodule

// File: tb/tb_pattern_tx.sv
// Scoreboard bench for pattern_tx: a driver pushes the expected bit stream,
// a negedge monitor pops and compares every emitted bit and hit count.
module tb_pattern_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        repeat_en;
  logic [15:0] pattern;
  logic [4:0]  len;
  logic        x, valid, busy, done;
  logic [7:0]  hit_cnt;
  logic        x2, valid2, busy2, done2;
  logic [1:0]  hit_cnt2;

  always #5 clk = ~clk;

  pattern_tx dut (
    .clk(clk), .rst(rst), .start(start), .pattern(pattern), .len(len),
    .repeat_en(repeat_en), .x(x), .valid(valid), .busy(busy), .done(done),
    .hit_cnt(hit_cnt)
  );

  pattern_tx #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .pattern(pattern), .len(len),
    .repeat_en(repeat_en), .x(x2), .valid(valid2), .busy(busy2), .done(done2),
    .hit_cnt(hit_cnt2)
  );

  typedef struct {
    logic b;
    int   cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   passed = 0;
  int   total  = 0;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic int sat(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  // Reference: the frame bits repeated, with a running count of "101" windows
  function automatic int model_push(input logic [15:0] pat, input int l, input int frames);
    logic bits[$];
    int   hits = 0;
    int   eff  = (l > 16) ? 16 : l;
    for (int f = 0; f < frames; f++)
      for (int i = eff - 1; i >= 0; i--) bits.push_back(pat[i]);
    for (int j = 0; j < bits.size(); j++) begin
      if (j >= 2 && bits[j-2] == 1'b1 && bits[j-1] == 1'b0 && bits[j] == 1'b1) hits++;
      exp_q.push_back('{bits[j], hits});
    end
    return hits;
  endfunction

  // Monitor: every valid bit must match the head of the scoreboard
  always @(negedge clk) begin
    if (valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_bit", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("x", x, mon_e.b);
        check("hit_cnt", hit_cnt, sat(mon_e.cnt, 255));
        check("hit_cnt_w2", hit_cnt2, sat(mon_e.cnt, 3));
        check("busy_with_valid", busy, 1);
      end
    end
  end

  task automatic run(input logic [15:0] pat, input int l, input int frames, input bit noise);
    int eff      = (l > 16) ? 16 : l;
    int n        = eff * frames;
    int drop     = (frames > 1) ? eff * (frames - 1) + $urandom_range(0, eff - 1) : 0;
    int done_at  = -1;
    int done_cnt = 0;
    int fin;
    @(negedge clk);
    pattern   = pat;
    len       = 5'(l);
    start     = 1'b1;
    repeat_en = (frames > 1);
    fin = model_push(pat, l, frames);
    @(posedge clk); #1;
    start = 1'b0;
    check("accept_busy", busy, 1);
    for (int c = 1; c <= n + 2; c++) begin
      if (c > drop) repeat_en = 1'b0;
      if (noise && c <= n) begin
        pattern = 16'($urandom);
        len     = 5'($urandom_range(0, 31));
        start   = ($urandom_range(0, 3) == 0);
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = c;
      end
      if (c == n) begin
        check("end_x", x, 0);
        check("end_valid", valid, 0);
        check("end_busy", busy, 0);
        check("end_hit_cnt", hit_cnt, sat(fin, 255));
        check("end_hit_cnt_w2", hit_cnt2, sat(fin, 3));
      end
    end
    start = 1'b0;
    check("done_cycle", done_at, n);
    check("done_pulses", done_cnt, 1);
    check("queue_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic idle_len0();
    @(negedge clk);
    len   = 5'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("len0_busy", busy, 0);
      check("len0_valid", valid, 0);
      check("len0_done", done, 0);
    end
  endtask

  task automatic reset_mid();
    @(negedge clk);
    pattern   = 16'hA5C3;
    len       = 5'd8;
    start     = 1'b1;
    repeat_en = 1'b0;
    void'(model_push(16'hA5C3, 8, 1));
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("rst_x", x, 0);
    check("rst_valid", valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_hit_cnt", hit_cnt, 0);
    exp_q.delete();
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      check("rst_hold_done", done, 0);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("post_rst_done", done, 0);
      check("post_rst_busy", busy, 0);
    end
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    repeat_en = 1'b0;
    pattern   = 16'h0000;
    len       = 5'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_x", x, 0);
    check("reset_valid", valid, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_hit_cnt", hit_cnt, 0);
    @(negedge clk);
    rst = 1'b0;

    run(16'h0005, 3, 1, 1'b0);
    run(16'h0535, 11, 1, 1'b0);
    run(16'h0002, 2, 3, 1'b0);
    idle_len0();
    run(16'($urandom), 20, 1, 1'b1);
    run(16'h0005, 3, 5, 1'b1);
    reset_mid();
    run(16'($urandom), 8, 1, 1'b0);
    run(16'h0002, 2, 300, 1'b0);
    for (int r = 0; r < 12; r++)
      run(16'($urandom), $urandom_range(1, 20), $urandom_range(1, 3), 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
